// File: rtl/obstacle_pkg.sv
// obstacle_pkg
//  Shared definitions for the obstacle controller: FSM state encoding,
//  screen geometry, sweep lengths and colours.
//  Sweep length N = OBS_W * (limit + 1). This is the number of pixels the
//  datapath covers in one pass, so its counters finish back at zero.
package obstacle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    LD_FG,
    DRAW,
    WAIT,
    LD_BG,
    ERASE,
    MOVE
  } state_e;

  localparam logic [7:0] X_START = 8'd149;
  localparam logic [7:0] Y_TOP   = 8'd20;
  localparam logic [7:0] STEP    = 8'd2;

  localparam int OBS_W     = 11;
  localparam int LIM_SHORT = 30;
  localparam int LIM_MID   = 60;
  localparam int LIM_TALL  = 90;

  localparam logic [9:0] SWEEP_SHORT = 10'(OBS_W * (LIM_SHORT + 1));  // 341
  localparam logic [9:0] SWEEP_MID   = 10'(OBS_W * (LIM_MID + 1));    // 671
  localparam logic [9:0] SWEEP_TALL  = 10'(OBS_W * (LIM_TALL + 1));   // 1001

  localparam logic [2:0] FG_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  // Final sweep-counter value for a given height code. The counter starts
  // at 0, so the last value is N-1.
  function automatic logic [9:0] sweep_last(input logic [3:0] h);
    logic [9:0] n;
    if (h < 4'd6)       n = SWEEP_SHORT;
    else if (h < 4'd11) n = SWEEP_MID;
    else                n = SWEEP_TALL;
    return n - 10'd1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
//  Free-running frame divider. tick is high for one cycle when the count
//  reaches FRAME_DIV-1. The count then wraps to 0.
//  Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset (count -> 0)
//   tick   out one-cycle frame strobe
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/obstacle_ctrl.sv
// obstacle_ctrl
//  Control FSM in front of the obstacle pixel datapath. It spawns an
//  obstacle at the right edge and latches a random height code. It draws
//  the obstacle, waits one frame, erases it, then steps it left. It
//  respawns once the obstacle has left the screen.
//  Optional feature macro: OBSTACLE_SPEEDUP_EN. When defined, every 8th
//  passed pulse raises the step by 1, up to a maximum of 7.
//  Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   start      in   level; leaves IDLE while high
//   random_in  in   [3:0] height code, sampled in SPAWN
//   x, y       out  [7:0] obstacle left column / top row
//   colour     out  [2:0] colour to datapath
//   ld_c       out  colour load strobe
//   enable     out  pixel-counter advance
//   plot       out  VGA write enable (same as enable)
//   height     out  [3:0] latched height code
//   passed     out  one-cycle pulse when the obstacle leaves the screen
//
//  state | meaning
//  IDLE  | wait for start
//  SPAWN | latch height, x back to right edge
//  LD_FG | load obstacle colour into datapath
//  DRAW  | sweep N pixels in obstacle colour
//  WAIT  | hold until frame tick
//  LD_BG | load background colour
//  ERASE | sweep N pixels in background colour
//  MOVE  | step left, or signal passed and respawn
module obstacle_ctrl
  import obstacle_pkg::*;
#(
  parameter int FRAME_DIV = 833333
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] random_in,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       ld_c,
  output logic       enable,
  output logic       plot,
  output logic [3:0] height,
  output logic       passed
);

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [3:0] height_q, height_d;
  logic [9:0] sweep_q, sweep_d;
  logic [7:0] step_w;
  logic       tick;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

`ifdef OBSTACLE_SPEEDUP_EN
  logic [2:0] step_q, step_d;
  logic [2:0] pass_cnt_q, pass_cnt_d;

  always_comb begin
    step_d     = step_q;
    pass_cnt_d = pass_cnt_q;
    if (passed) begin
      pass_cnt_d = pass_cnt_q + 3'd1;
      if (pass_cnt_q == 3'd7 && step_q != 3'd7) step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q     <= 3'(STEP);
      pass_cnt_q <= '0;
    end else begin
      step_q     <= step_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign step_w = {5'd0, step_q};
`else
  assign step_w = STEP;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    height_d = height_q;
    sweep_d  = sweep_q;
    colour   = BG_COLOUR;
    ld_c     = 1'b0;
    enable   = 1'b0;
    passed   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SPAWN;
      end
      SPAWN: begin
        height_d = random_in;
        x_d      = X_START;
        state_d  = LD_FG;
      end
      LD_FG: begin
        colour  = FG_COLOUR;
        ld_c    = 1'b1;
        sweep_d = '0;
        state_d = DRAW;
      end
      DRAW: begin
        colour = FG_COLOUR;
        enable = 1'b1;
        if (sweep_q == sweep_last(height_q)) state_d = WAIT;
        else                                 sweep_d = sweep_q + 10'd1;
      end
      WAIT: begin
        colour = FG_COLOUR;
        if (tick) state_d = LD_BG;
      end
      LD_BG: begin
        ld_c    = 1'b1;
        sweep_d = '0;
        state_d = ERASE;
      end
      ERASE: begin
        enable = 1'b1;
        if (sweep_q == sweep_last(height_q)) state_d = MOVE;
        else                                 sweep_d = sweep_q + 10'd1;
      end
      MOVE: begin
        // Subtracting would wrap past column 0, so the obstacle is treated
        // as having left the screen.
        if (x_q < step_w) begin
          passed  = 1'b1;
          state_d = SPAWN;
        end else begin
          x_d     = x_q - step_w;
          state_d = LD_FG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= X_START;
      height_q <= '0;
      sweep_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      height_q <= height_d;
      sweep_q  <= sweep_d;
    end
  end

  assign plot   = enable;
  assign x      = x_q;
  assign y      = Y_TOP;
  assign height = height_q;

endmodule

// File: tb/tb_obstacle_ctrl.sv
// tb_obstacle_ctrl
//  Scoreboard bench for obstacle_ctrl with FRAME_DIV=16. The driver pushes
//  the expected lifetime of each obstacle into a queue: draw/erase bursts
//  at each x, then a passed event. The monitor measures each enable burst
//  and each passed pulse, and compares them with the front of the queue.
module tb_obstacle_ctrl;

  localparam int FDIV = 16;
  localparam int FG   = 2;
  localparam int BG   = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] random_in = 4'd0;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       ld_c, enable, plot, passed;
  logic [3:0] height;

  obstacle_ctrl #(.FRAME_DIV(FDIV)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .random_in (random_in),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .ld_c      (ld_c),
    .enable    (enable),
    .plot      (plot),
    .height    (height),
    .passed    (passed)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_pass;
    int xv;
    int col;
    int len;
    int h;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, want);
    end
  endfunction

  function automatic void fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Reference model: pixel count per sweep from the height code, then the
  // whole path from the right edge to the left edge in steps of 2.
  function automatic int sweep_len(input int h);
    int lim;
    lim = (h < 6) ? 30 : (h < 11) ? 60 : 90;
    return 11 * (lim + 1);
  endfunction

  task automatic push_life(input int h);
    exp_t e;
    for (int xx = 149; xx >= 0; xx -= 2) begin
      e = '{is_pass: 1'b0, xv: xx, col: FG, len: sweep_len(h), h: h};
      expq.push_back(e);
      e.col = BG;
      expq.push_back(e);
      if (xx < 2) begin
        e = '{is_pass: 1'b1, xv: xx, col: 0, len: 0, h: h};
        expq.push_back(e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  int   mc = 0;
  bit   tick_now;
  bit   in_burst = 0;
  int   blen = 0, bx = 0, bcol = 0, ldcol = 0;
  bit   last_ld = 0, last_pass = 0, x_moved = 0;
  int   wst = 0;
  int   bursts_done = 0, passes_seen = 0;
  exp_t me;

  initial forever begin
    @(negedge clock);
    // The frame count runs freely from reset; a tick occurs on count 15.
    tick_now = (mc == FDIV - 1);
    mc = reset ? 0 : (tick_now ? 0 : mc + 1);
    if (reset) begin
      in_burst  = 0;
      wst       = 0;
      last_ld   = 0;
      last_pass = 0;
    end else begin
      chk("plot_eq_enable", int'(plot), int'(enable));
      if (wst == 2) begin
        chk("ld_bg_after_tick", int'(ld_c), 1);
        chk("ld_bg_colour", int'(colour), BG);
        wst = 0;
      end
      if (ld_c) begin
        ldcol = int'(colour);
        chk("ld_c_single", int'(last_ld), 0);
      end
      if (enable) begin
        if (!in_burst) begin
          in_burst = 1;
          blen     = 0;
          bx       = int'(x);
          bcol     = ldcol;
          x_moved  = 0;
          chk("ld_c_before_burst", int'(last_ld), 1);
        end else if (int'(x) != bx) begin
          x_moved = 1;
        end
        blen++;
      end else if (in_burst) begin
        in_burst = 0;
        bursts_done++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_burst: x=%0d len=%0d, wanted none", bx, blen);
        end else begin
          me = expq.pop_front();
          chk("burst_kind", 0, int'(me.is_pass));
          chk("burst_x", bx, me.xv);
          chk("burst_x_held", int'(x_moved), 0);
          chk("burst_colour", bcol, me.col);
          chk("burst_len", blen, me.len);
          chk("burst_height", int'(height), me.h);
        end
        if (bcol == FG) wst = 1;
      end
      if (wst == 1) begin
        if (ld_c) chk("ld_bg_early", int'(ld_c), 0);
        if (tick_now) wst = 2;
      end
      if (passed) begin
        chk("passed_single", int'(last_pass), 0);
        passes_seen++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_passed: x=%0d, wanted none", x);
        end else begin
          me = expq.pop_front();
          chk("passed_kind", 1, int'(me.is_pass));
          chk("passed_x", int'(x), me.xv);
        end
      end
      last_ld   = ld_c;
      last_pass = passed;
    end
  end

  // ---------------- driver ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, int'(x), 149);
    chk({tag, "_y"}, int'(y), 20);
    chk({tag, "_colour"}, int'(colour), 0);
    chk({tag, "_height"}, int'(height), 0);
    chk({tag, "_ld_c"}, int'(ld_c), 0);
    chk({tag, "_enable"}, int'(enable), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_passed"}, int'(passed), 0);
  endtask

  task automatic start_obstacle();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    chk("spawn_ld_c", int'(ld_c), 1);
    chk("spawn_colour", int'(colour), FG);
  endtask

  // Wait for `target` completed bursts, then reset at about draw cycle 100.
  task automatic abort_at_draw(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (bursts_done >= target && in_burst && blen >= 100) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("abort_wait");
    chk("abort_in_draw", bcol, FG);
    reset = 1'b1;
    expq.delete();
    @(posedge clock); #1;
    check_reset_vals("abort");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int v2, base, hi_cnt;
    bit ok;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_enable", int'(enable), 0);
    chk("idle_ld_c", int'(ld_c), 0);

    // Full lifetime at height 3, then respawn with a new random height.
    v2        = int'($urandom_range(0, 15));
    base      = bursts_done;
    random_in = 4'd3;
    push_life(3);
    push_life(v2);
    start_obstacle();
    ok = 0;
    for (int i = 0; i < 60000; i++) begin
      @(posedge clock); #1;
      if (passes_seen >= 1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("first_pass_wait");
    random_in = 4'(v2);
    abort_at_draw(base + 152, 5000);

    // Tall obstacles and one random mid-height obstacle, one frame each.
    for (int k = 0; k < 3; k++) begin
      int v;
      v = (k == 0) ? 12 : (k == 1) ? 15 : int'($urandom_range(6, 10));
      random_in = 4'(v);
      base = bursts_done;
      push_life(v);
      start_obstacle();
      random_in = 4'(int'($urandom_range(0, 15)));
      abort_at_draw(base + 2, 5000);
    end

    // With start low the controller stays idle.
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (enable || ld_c) hi_cnt++;
    end
    chk("idle_hold", hi_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clock);
    fail_now("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
